// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, sync, display enable, look-ahead read strobe.
// Optional test-pattern output on o_rgb when VIDEO_TPG_EN is defined.
//
// state  | meaning
// S_IDLE | counters held at 0, outputs at idle levels, waiting for enable
// S_RUN  | counters advance every pixel clock, outputs follow counters one cycle later
module video_timing_gen #(
  parameter int   HDISP     = 800,
  parameter int   HFP       = 40,
  parameter int   HPULSE    = 128,
  parameter int   HBP       = 88,
  parameter int   VDISP     = 480,
  parameter int   VFP       = 1,
  parameter int   VPULSE    = 3,
  parameter int   VBP       = 21,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   LOOKAHEAD = 1,
  localparam int  HTOTAL    = HDISP + HFP + HPULSE + HBP,
  localparam int  VTOTAL    = VDISP + VFP + VPULSE + VBP,
  localparam int  XW        = $clog2(HTOTAL),
  localparam int  YW        = $clog2(VTOTAL)
) (
  input  logic          i_pixel_clk,
  input  logic          i_pixel_rst,
  input  logic          i_enable,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic          o_de_req,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_sof,
  output logic          o_eol
`ifdef VIDEO_TPG_EN
  ,
  output logic [23:0]   o_rgb
`endif
);

  generate
    if (LOOKAHEAD < 0 || LOOKAHEAD > HBP) begin : g_bad_lookahead
      $error("video_timing_gen: LOOKAHEAD must lie in 0..HBP");
    end
    if (HDISP == 0 || HFP == 0 || HPULSE == 0 || HBP == 0 ||
        VDISP == 0 || VFP == 0 || VPULSE == 0 || VBP == 0) begin : g_bad_timing
      $error("video_timing_gen: timing parameters must be non-zero");
    end
`ifdef VIDEO_TPG_EN
    if (HDISP % 8 != 0) begin : g_bad_bars
      $error("video_timing_gen: HDISP must be a multiple of 8 for the test pattern");
    end
`endif
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [XW-1:0] r_hcnt;
  logic [YW-1:0] r_vcnt;

  logic          r_hs, r_vs, r_de, r_de_req, r_sof, r_eol;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  int   w_h, w_v, w_ha, w_va;
  logic w_h_last, w_v_last, w_vis, w_hs_act, w_vs_act, w_wrap, w_req;

  always_comb begin
    w_h      = int'(r_hcnt);
    w_v      = int'(r_vcnt);
    w_h_last = (w_h == HTOTAL - 1);
    w_v_last = (w_v == VTOTAL - 1);
    w_vis    = (w_h < HDISP) && (w_v < VDISP);
    w_hs_act = (w_h >= HDISP + HFP) && (w_h < HDISP + HFP + HPULSE);
    w_vs_act = (w_v >= VDISP + VFP) && (w_v < VDISP + VFP + VPULSE);
    // Position LOOKAHEAD pixels ahead; it can spill into the next line or frame.
    w_ha     = w_h + LOOKAHEAD;
    w_va     = w_v;
    w_wrap   = 1'b0;
    if (w_ha >= HTOTAL) begin
      w_ha = w_ha - HTOTAL;
      w_va = w_v + 1;
      if (w_va == VTOTAL) begin
        w_va   = 0;
        w_wrap = 1'b1;
      end
    end
    // A lead into the next frame is only issued if that frame will actually run.
    w_req    = (w_ha < HDISP) && (w_va < VDISP) && (!w_wrap || i_enable);
  end

`ifdef VIDEO_TPG_EN
  localparam int BARW = HDISP / 8;

  logic [2:0]  w_bar;
  logic [23:0] w_color;
  logic [23:0] r_rgb;

  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (w_h >= k * BARW) w_bar = 3'(k);
    end
    w_color = 24'h000000;
    case (w_bar)
      3'd0: w_color = 24'hFFFFFF;
      3'd1: w_color = 24'hFFFF00;
      3'd2: w_color = 24'h00FFFF;
      3'd3: w_color = 24'h00FF00;
      3'd4: w_color = 24'hFF00FF;
      3'd5: w_color = 24'hFF0000;
      3'd6: w_color = 24'h0000FF;
      3'd7: w_color = 24'h000000;
      default: w_color = 24'h000000;
    endcase
  end

  always_ff @(posedge i_pixel_clk) begin
    if (i_pixel_rst || r_state != S_RUN || !w_vis) r_rgb <= 24'h000000;
    else                                           r_rgb <= w_color;
  end

  assign o_rgb = r_rgb;
`endif

  always_ff @(posedge i_pixel_clk) begin
    if (i_pixel_rst) begin
      r_state  <= S_IDLE;
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_hs     <= ~HS_POL;
      r_vs     <= ~VS_POL;
      r_de     <= 1'b0;
      r_de_req <= 1'b0;
      r_sof    <= 1'b0;
      r_eol    <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_h_last) begin
            r_hcnt <= '0;
            if (w_v_last) begin
              r_vcnt <= '0;
              if (!i_enable) r_state <= S_IDLE;
            end else begin
              r_vcnt <= r_vcnt + 1'b1;
            end
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (r_state == S_RUN) begin
        r_hs     <= w_hs_act ? HS_POL : ~HS_POL;
        r_vs     <= w_vs_act ? VS_POL : ~VS_POL;
        r_de     <= w_vis;
        r_de_req <= (LOOKAHEAD == 0) ? w_vis : w_req;
        r_sof    <= (w_h == 0) && (w_v == 0);
        r_eol    <= (w_h == HDISP - 1) && (w_v < VDISP);
        r_x      <= r_hcnt;
        r_y      <= r_vcnt;
      end else begin
        r_hs     <= ~HS_POL;
        r_vs     <= ~VS_POL;
        r_de     <= 1'b0;
        r_de_req <= 1'b0;
        r_sof    <= 1'b0;
        r_eol    <= 1'b0;
        r_x      <= '0;
        r_y      <= '0;
      end
    end
  end

  assign o_hs     = r_hs;
  assign o_vs     = r_vs;
  assign o_de     = r_de;
  assign o_de_req = r_de_req;
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_sof    = r_sof;
  assign o_eol    = r_eol;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: linear frame-position reference model, random enable/reset.
module tb_video_timing_gen;
  localparam int HD = 160, HF = 4, HP = 8, HB = 12;
  localparam int VD = 90, VF = 2, VP = 3, VB = 5;
  localparam int LA = 2;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic hs, vs, de, de_req, sof, eol;
  logic [7:0] x;
  logic [6:0] y;
`ifdef VIDEO_TPG_EN
  logic [23:0] rgb;
`endif

  video_timing_gen #(
    .HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(LA)
  ) dut (
    .i_pixel_clk(clk), .i_pixel_rst(rst), .i_enable(en),
    .o_hs(hs), .o_vs(vs), .o_de(de), .o_de_req(de_req),
    .o_x(x), .o_y(y), .o_sof(sof), .o_eol(eol)
`ifdef VIDEO_TPG_EN
    , .o_rgb(rgb)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: run flag plus linear position within the frame.
  bit   m_run = 1'b0;
  int   m_pos = 0;
  int   n_out = 0;
  int   age   = 0;
  logic e_de;
  logic [19:0] e_vec;
  logic [23:0] e_rgb;
  bit   h_req[8];
  bit   h_rst[8];
  bit   r_chk, r_exp, r_obs;

  wire [19:0] w_obs = {hs, vs, de, sof, eol, x, y};
  localparam logic [19:0] IDLE_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0};

  function automatic logic [23:0] bar_color(input int xx);
    case (xx / (HD / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic tick(input bit i_r, input bit i_e);
    int px, py;
    bit live;
    rst  = i_r;
    en   = i_e;
    live = !i_r && m_run;
    px   = m_pos % HT;
    py   = m_pos / HT;
    if (live) begin
      e_de  = (px < HD) && (py < VD);
      e_vec = {!(px >= HD + HF && px < HD + HF + HP), !(py >= VD + VF && py < VD + VF + VP),
               e_de, (m_pos == 0), (px == HD - 1 && py < VD), 8'(px), 7'(py)};
      e_rgb = e_de ? bar_color(px) : 24'h0;
    end else begin
      e_de  = 1'b0;
      e_vec = IDLE_VEC;
      e_rgb = 24'h0;
    end
    if (i_r) begin
      m_run = 1'b0;
      m_pos = 0;
    end else if (!m_run) begin
      m_run = i_e;
    end else if (m_pos == FT - 1) begin
      m_pos = 0;
      m_run = i_e;
    end else begin
      m_pos++;
    end
    @(posedge clk);
    #1;
    n_out++;
    age = live ? age + 1 : 0;
    h_req[n_out % 8] = de_req;
    h_rst[n_out % 8] = i_r;
    // de_req at cycle n-LA must equal de at cycle n, unless the run was too young to lead.
    r_chk = (n_out > LA);
    for (int k = 0; k < LA; k++) if (h_rst[(n_out - k) % 8]) r_chk = 1'b0;
    r_obs = (n_out > LA) ? h_req[(n_out - LA) % 8] : 1'b0;
    r_exp = e_de && (age > LA);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)));
      n_assert++;
      if ({w_obs, de_req} !== {IDLE_VEC, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d got %h required %h", n_out, {w_obs, de_req}, {IDLE_VEC, 1'b0});
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      n_assert++;
      if (w_obs !== e_vec || de_req !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d got %h/%b required %h/0", n_out, w_obs, de_req, e_vec);
      end
    end
  endtask

  task automatic test_startup();
    tick(1'b0, 1'b1);
    n_assert++;
    if (w_obs !== IDLE_VEC) begin
      n_fail++;
      $display("FAIL start_first_cycle got %h required %h", w_obs, IDLE_VEC);
    end
  endtask

  task automatic test_full_frame();
    int c_de = 0, c_hs = 0, c_vs = 0, c_req = 0, c_sof = 0, c_eol = 0, c_de5 = 0;
    int hs_fall_x = -1, vs_fall_x = -1, vs_fall_y = -1, last_fall = -1;
    logic p_hs = 1'b1, p_vs = 1'b1;
    for (int i = 0; i < FT; i++) begin
      tick(1'b0, 1'b1);
      if (i == 0) begin
        n_assert++;
        if ({sof, de, x, y} !== {1'b1, 1'b1, 8'd0, 7'd0}) begin
          n_fail++;
          $display("FAIL sof_second_cycle got sof=%b de=%b x=%0d y=%0d required 1 1 0 0", sof, de, x, y);
        end
      end
      n_assert++;
      if (w_obs !== e_vec) begin
        n_fail++;
        $display("FAIL frame_outputs cycle %0d got %h required %h", n_out, w_obs, e_vec);
      end
      if (r_chk) begin
        n_assert++;
        if (r_obs !== r_exp) begin
          n_fail++;
          $display("FAIL frame_de_req cycle %0d got %b required %b", n_out - LA, r_obs, r_exp);
        end
      end
`ifdef VIDEO_TPG_EN
      n_assert++;
      if (rgb !== e_rgb) begin
        n_fail++;
        $display("FAIL frame_rgb cycle %0d got %h required %h", n_out, rgb, e_rgb);
      end
      if (y == 7'd0 && (x == 8'd0 || x == 8'd20 || x == 8'd159 || x == 8'd170)) begin
        n_assert++;
        if (rgb !== ((x == 8'd0) ? 24'hFFFFFF : (x == 8'd20) ? 24'hFFFF00 : 24'h000000)) begin
          n_fail++;
          $display("FAIL tpg_bar x=%0d got %h", x, rgb);
        end
      end
`endif
      c_de  += int'(de);
      c_hs  += int'(!hs);
      c_vs  += int'(!vs);
      c_req += int'(de_req);
      c_sof += int'(sof);
      c_eol += int'(eol);
      if (y == 7'd5) c_de5 += int'(de);
      if (p_hs && !hs) begin
        if (hs_fall_x < 0) hs_fall_x = int'(x);
        if (last_fall >= 0) begin
          n_assert++;
          if (i - last_fall !== HT) begin
            n_fail++;
            $display("FAIL hs_period got %0d required %0d", i - last_fall, HT);
          end
        end
        last_fall = i;
      end
      if (p_vs && !vs && vs_fall_y < 0) begin
        vs_fall_x = int'(x);
        vs_fall_y = int'(y);
      end
      p_hs = hs;
      p_vs = vs;
    end
    n_assert++; if (c_de  !== VD * HD) begin n_fail++; $display("FAIL de_count got %0d required %0d", c_de, VD * HD); end
    n_assert++; if (c_de5 !== HD)      begin n_fail++; $display("FAIL de_per_line got %0d required %0d", c_de5, HD); end
    n_assert++; if (c_hs  !== HP * VT) begin n_fail++; $display("FAIL hs_count got %0d required %0d", c_hs, HP * VT); end
    n_assert++; if (c_vs  !== VP * HT) begin n_fail++; $display("FAIL vs_count got %0d required %0d", c_vs, VP * HT); end
    n_assert++; if (c_req !== VD * HD) begin n_fail++; $display("FAIL de_req_count got %0d required %0d", c_req, VD * HD); end
    n_assert++; if (c_sof !== 1)       begin n_fail++; $display("FAIL sof_count got %0d required 1", c_sof); end
    n_assert++; if (c_eol !== VD)      begin n_fail++; $display("FAIL eol_count got %0d required %0d", c_eol, VD); end
    n_assert++; if (hs_fall_x !== HD + HF) begin n_fail++; $display("FAIL hs_start got x=%0d required %0d", hs_fall_x, HD + HF); end
    n_assert++;
    if (vs_fall_y !== VD + VF || vs_fall_x !== 0) begin
      n_fail++;
      $display("FAIL vs_start got x=%0d y=%0d required x=0 y=%0d", vs_fall_x, vs_fall_y, VD + VF);
    end
  endtask

  task automatic test_stop();
    bit saw_end = 1'b0;
    bit done    = 1'b0;
    // Random mid-frame drops of enable before line 40 must be ignored.
    for (int i = 0; i < FT && !(m_run && m_pos == 40 * HT); i++) begin
      tick(1'b0, ($urandom_range(0, 3) != 0));
      n_assert++;
      if (w_obs !== e_vec) begin
        n_fail++;
        $display("FAIL glitch_outputs cycle %0d got %h required %h", n_out, w_obs, e_vec);
      end
    end
    for (int i = 0; i < FT + 4 && !done; i++) begin
      tick(1'b0, 1'b0);
      n_assert++;
      if (w_obs !== e_vec) begin
        n_fail++;
        $display("FAIL stop_outputs cycle %0d got %h required %h", n_out, w_obs, e_vec);
      end
      if (r_chk) begin
        n_assert++;
        if (r_obs !== r_exp) begin
          n_fail++;
          $display("FAIL stop_de_req cycle %0d got %b required %b", n_out - LA, r_obs, r_exp);
        end
      end
      if (y == 7'd99 && x == 8'd183) saw_end = 1'b1;
      done = !m_run;
    end
    n_assert++;
    if (!done || !saw_end) begin
      n_fail++;
      $display("FAIL stop_completion got done=%b end_seen=%b required 1 1", done, saw_end);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      n_assert++;
      if ({w_obs, de_req} !== {IDLE_VEC, 1'b0}) begin
        n_fail++;
        $display("FAIL stopped_idle got %h required %h", {w_obs, de_req}, {IDLE_VEC, 1'b0});
      end
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    n_assert++;
    if ({sof, de, x, y} !== {1'b1, 1'b1, 8'd0, 7'd0}) begin
      n_fail++;
      $display("FAIL restart_sof got sof=%b de=%b x=%0d y=%0d required 1 1 0 0", sof, de, x, y);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    for (int i = 0; i < FT && !hit; i++) begin
      tick(1'b0, 1'b1);
      n_assert++;
      if (w_obs !== e_vec) begin
        n_fail++;
        $display("FAIL pre_reset_outputs cycle %0d got %h required %h", n_out, w_obs, e_vec);
      end
      hit = (x == 8'd50 && y == 7'd30);
    end
    n_assert++;
    if (!hit) begin
      n_fail++;
      $display("FAIL reset_point_reached got 0 required 1");
    end
    tick(1'b1, 1'b1);
    n_assert++;
    if ({w_obs, de_req} !== {IDLE_VEC, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_idle got %h required %h", {w_obs, de_req}, {IDLE_VEC, 1'b0});
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    n_assert++;
    if ({sof, de, x, y} !== {1'b1, 1'b1, 8'd0, 7'd0}) begin
      n_fail++;
      $display("FAIL post_reset_sof got sof=%b de=%b x=%0d y=%0d required 1 1 0 0", sof, de, x, y);
    end
  endtask

  task automatic test_random();
    bit r_en = 1'b1;
    bit r_rs;
    for (int i = 0; i < 8000; i++) begin
      // Keep enable stable across the frame-end lead window.
      if ((!m_run || m_pos < FT - LA - 3) && $urandom_range(0, 199) == 0) r_en = !r_en;
      r_rs = ($urandom_range(0, 2999) == 0);
      tick(r_rs, r_en);
      n_assert++;
      if (w_obs !== e_vec) begin
        n_fail++;
        $display("FAIL random_outputs cycle %0d got %h required %h", n_out, w_obs, e_vec);
      end
      if (r_chk) begin
        n_assert++;
        if (r_obs !== r_exp) begin
          n_fail++;
          $display("FAIL random_de_req cycle %0d got %b required %b", n_out - LA, r_obs, r_exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_full_frame();
    test_stop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
